// File: rtl/db_req_arbiter.sv
// ---------------------------------------------------------------------------
// db_req_arbiter
//
// Shares one lookup database between NUM_REQ requesters. Requests are granted
// round-robin, forwarded to the database one at a time, and the result (or a
// timeout if the database stays silent) is returned to the owning requester
// as a single-cycle pulse.
//
// Parameters
//   KEY_SIZE  lookup key width in bits
//   NUM_REQ   number of requesters (2..8)
//   TIMEOUT   cycles to wait for a database result before giving up (2..65535)
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_valid         per-requester request
//   req_key/req_flag  per-requester key and op flags (packed, requester i at slot i)
//   req_ready         combinational accept strobe, one-hot, only while idle
//   resp_valid        registered one-hot response pulse
//   resp_flag         result flag (0 on timeout)
//   resp_timeout      response was produced by the timeout
//   db_key/db_flag    latched key and op presented to the database
//   db_valid          request to the database (high while issuing)
//   db_ready          database accepts the request
//   db_out_valid      database result strobe
//   db_out_flag       database result flag
//   req_cnt           accepted requests, saturating
//   timeout_cnt       timeouts, saturating
// ---------------------------------------------------------------------------
module db_req_arbiter #(
  parameter int KEY_SIZE = 96,
  parameter int NUM_REQ  = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*KEY_SIZE-1:0] req_key,
  input  logic [NUM_REQ*4-1:0]        req_flag,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          resp_valid,
  output logic [3:0]                  resp_flag,
  output logic                        resp_timeout,
  output logic [KEY_SIZE-1:0]         db_key,
  output logic [3:0]                  db_flag,
  output logic                        db_valid,
  input  logic                        db_ready,
  input  logic                        db_out_valid,
  input  logic [3:0]                  db_out_flag,
  output logic [15:0]                 req_cnt,
  output logic [15:0]                 timeout_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  localparam logic [15:0]        TIMER_LAST = 16'(TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] LAST_RST   = NUM_REQ'(1) << (NUM_REQ - 1);

  state_t              r_state;
  // Last granted requester, kept one-hot; it is also the owner of the
  // outstanding lookup, since it only changes on a grant.
  logic [NUM_REQ-1:0]  r_last_oh;
  logic [15:0]         r_timer;
  logic [KEY_SIZE-1:0] r_db_key;
  logic [3:0]          r_db_flag;
  logic [15:0]         r_req_cnt;
  logic [15:0]         r_timeout_cnt;
  logic [NUM_REQ-1:0]  r_resp_valid;
  logic [3:0]          r_resp_flag;
  logic                r_resp_timeout;

  logic [NUM_REQ-1:0]  w_hi_mask;
  logic [NUM_REQ-1:0]  w_req_hi;
  logic [NUM_REQ-1:0]  w_pick_hi;
  logic [NUM_REQ-1:0]  w_pick_all;
  logic [NUM_REQ-1:0]  w_grant_oh;
  logic [KEY_SIZE-1:0] w_key_acc  [NUM_REQ+1];
  logic [3:0]          w_flag_acc [NUM_REQ+1];
  logic [KEY_SIZE-1:0] w_sel_key;
  logic [3:0]          w_sel_flag;

  // Round-robin: requesters strictly above the last grant get priority; if
  // none of them is requesting, wrap around to the lowest requesting index.
  // x & (~x + 1) isolates the lowest set bit.
  assign w_req_hi   = req_valid & w_hi_mask;
  assign w_pick_hi  = w_req_hi & (~w_req_hi + NUM_REQ'(1));
  assign w_pick_all = req_valid & (~req_valid + NUM_REQ'(1));
  assign w_grant_oh = (|w_req_hi) ? w_pick_hi : w_pick_all;

  assign w_key_acc[0]  = '0;
  assign w_flag_acc[0] = '0;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      if (gi == 0) begin : g_lsb
        assign w_hi_mask[gi] = 1'b0;
      end else begin : g_upper
        // Bit gi lies above the last grant when the grant sits below it.
        assign w_hi_mask[gi] = |r_last_oh[gi-1:0];
      end
      // One-hot AND-OR mux selecting the granted requester's key and flag.
      assign w_key_acc[gi+1]  = w_key_acc[gi] |
                                (w_grant_oh[gi] ? req_key[gi*KEY_SIZE +: KEY_SIZE] : '0);
      assign w_flag_acc[gi+1] = w_flag_acc[gi] |
                                (w_grant_oh[gi] ? req_flag[gi*4 +: 4] : 4'h0);
    end
  endgenerate

  assign w_sel_key  = w_key_acc[NUM_REQ];
  assign w_sel_flag = w_flag_acc[NUM_REQ];

  // No accept strobe while reset is held, so nothing is handed over that
  // the reset is about to discard.
  assign req_ready    = (r_state == ST_IDLE && !rst) ? w_grant_oh : '0;
  assign db_valid     = (r_state == ST_ISSUE);
  assign db_key       = r_db_key;
  assign db_flag      = r_db_flag;
  assign resp_valid   = r_resp_valid;
  assign resp_flag    = r_resp_flag;
  assign resp_timeout = r_resp_timeout;
  assign req_cnt      = r_req_cnt;
  assign timeout_cnt  = r_timeout_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_last_oh      <= LAST_RST;
      r_timer        <= '0;
      r_db_key       <= '0;
      r_db_flag      <= '0;
      r_req_cnt      <= '0;
      r_timeout_cnt  <= '0;
      r_resp_valid   <= '0;
      r_resp_flag    <= '0;
      r_resp_timeout <= 1'b0;
    end else begin
      // Response outputs are single-cycle pulses.
      r_resp_valid   <= '0;
      r_resp_flag    <= '0;
      r_resp_timeout <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (|req_valid) begin
            r_last_oh <= w_grant_oh;
            r_db_key  <= w_sel_key;
            r_db_flag <= w_sel_flag;
            if (r_req_cnt != 16'hFFFF) begin
              r_req_cnt <= r_req_cnt + 16'd1;
            end
            r_state <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (db_ready) begin
            r_timer <= '0;
            r_state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          // A result arriving on the expiry cycle still counts as a result.
          if (db_out_valid) begin
            r_resp_valid <= r_last_oh;
            r_resp_flag  <= db_out_flag;
            r_state      <= ST_IDLE;
          end else if (r_timer == TIMER_LAST) begin
            r_resp_valid   <= r_last_oh;
            r_resp_timeout <= 1'b1;
            if (r_timeout_cnt != 16'hFFFF) begin
              r_timeout_cnt <= r_timeout_cnt + 16'd1;
            end
            r_state <= ST_IDLE;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
